// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the fetch PC front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  // Bits of pc that select the starting slot inside a fetch group.
  function automatic int slot_bits(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 0;
  endfunction

  // Same as slot_bits but never zero, so it can size a port.
  function automatic int off_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

  // Bits of pc cleared to form the group base address.
  function automatic int group_bits(input int fetch_width);
    return $clog2(INSTR_BYTES * fetch_width);
  endfunction

endpackage

// File: rtl/fetch_mask_gen.sv
// Slot-valid mask: slot i is valid when i >= starting slot offset.
// Latency: combinational.
// Backpressure: none; en forces the mask to zero when no group is offered.
// Ports: en (group offered), offset (starting slot), mask (FETCH_WIDTH thermometer).
module fetch_mask_gen
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int OFF_W       = off_width(FETCH_WIDTH)
) (
  input  logic                   en,
  input  logic [OFF_W-1:0]       offset,
  output logic [FETCH_WIDTH-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = en && (offset <= OFF_W'(i));
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: offers aligned multi-instruction groups, handles branch/flush redirects with an epoch.
// Latency: a redirect on cycle N shows its target on cycle N+1; a fire advances to the next group base next cycle.
// Backpressure: fetch_pc holds while fetch_valid && !fetch_ready; stall drops fetch_valid and freezes advance.
// Ports: clk, rst_n; stall, fetch_ready; branch_taken/branch_target; flush/correct_pc;
//        fetch_valid, fetch_pc, fetch_mask, fetch_epoch; misalign_fault, fault_pc.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FETCH_WIDTH  = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              EPOCH_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   fetch_ready,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  input  logic                   flush,
  input  logic [XLEN-1:0]        correct_pc,
  output logic                   fetch_valid,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic [EPOCH_W-1:0]     fetch_epoch,
  output logic                   misalign_fault,
  output logic [XLEN-1:0]        fault_pc
);

  localparam int              SLOT_W      = slot_bits(FETCH_WIDTH);
  localparam int              OFF_W       = off_width(FETCH_WIDTH);
  localparam int              GRP_W       = group_bits(FETCH_WIDTH);
  localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(INSTR_BYTES * FETCH_WIDTH);

  generate
    if ((FETCH_WIDTH < 1) || (FETCH_WIDTH > 8) || ((FETCH_WIDTH & (FETCH_WIDTH - 1)) != 0)) begin : g_bad_width
      $error("fetch_pc_unit: FETCH_WIDTH must be a power of 2 in 1..8");
    end
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_vector
      $error("fetch_pc_unit: RESET_VECTOR must be 4-byte aligned");
    end
  endgenerate

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  group_base;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  redir_pc;
  logic             redir;
  logic             fire;
  logic [OFF_W-1:0] offset;

  assign fetch_valid    = (state == RUN) && !stall;
  assign fire           = fetch_valid && fetch_ready;
  assign fetch_pc       = pc;
  assign misalign_fault = (state == FAULT);

  // Sequential advance always lands on the next group base, so a group
  // entered mid-way is followed by a fully populated one. Wraps at 2^XLEN.
  assign group_base = {pc[XLEN-1:GRP_W], {GRP_W{1'b0}}};
  assign seq_pc     = group_base + GROUP_BYTES;

  // Flush wins over branch; a branch only counts while running, and
  // stall does not block either one. One redirect = one epoch bump.
  always_comb begin
    redir    = flush || (branch_taken && (state == RUN));
    redir_pc = flush ? correct_pc : branch_target;
  end

  generate
    if (SLOT_W > 0) begin : g_offset
      assign offset = pc[2 +: OFF_W];
    end else begin : g_no_offset
      assign offset = '0;
    end
  endgenerate

  fetch_mask_gen #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .OFF_W       (OFF_W)
  ) u_mask_gen (
    .en     (fetch_valid),
    .offset (offset),
    .mask   (fetch_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      fetch_epoch <= '0;
      fault_pc    <= '0;
    end else if (redir) begin
      pc          <= redir_pc;
      fetch_epoch <= fetch_epoch + EPOCH_W'(1);
      if (redir_pc[1:0] != 2'b00) begin
        state    <= FAULT;
        fault_pc <= redir_pc;
      end else begin
        state <= RUN;
      end
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (fire) pc <= seq_pc;
        FAULT:   state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
